// File: rtl/projective_to_affine.sv
// projective_to_affine: converts a projective Edwards25519 point (X:Y:Z) to
// affine (X/Z, Y/Z) mod P. Z^-1 = Z^(P-2) is computed with a fixed,
// constant-time square-and-multiply schedule on one bit-serial multiplier.
// Every multiply takes exactly WIDTH cycles: one load, then WIDTH-1 steps.
// Optional build macro: ZERO_CHECK_EN flags Z==0 on out_err and forces the
// outputs to zero; the full latency is still spent.
module projective_to_affine #(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] P     = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             out_err
);

    localparam int               CW  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] EXP = P - WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXP_SQR,
        S_EXP_MUL,
        S_FIN_X,
        S_FIN_Y,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] x_reg, y_reg, z_reg, r_reg;
    logic [WIDTH-1:0] x_res_reg, y_res_reg;
    logic [WIDTH-1:0] a_reg, b_sh_reg, acc_reg;
    logic [CW-1:0]    cnt_reg, bit_idx_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] x_out_reg, y_out_reg;

    logic [WIDTH-1:0] op_a, op_b, acc_next;
    logic [WIDTH:0]   dbl, dbl_red, sum, sum_red;
    logic             in_mul, mul_last, exp_bit, accept, force_zero;
    logic [1:0]       unused_bits;

    assign in_ready  = (state_reg == S_IDLE);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_reg;
    assign x_out     = x_out_reg;
    assign y_out     = y_out_reg;

    assign in_mul   = (state_reg == S_EXP_SQR) || (state_reg == S_EXP_MUL) ||
                      (state_reg == S_FIN_X)   || (state_reg == S_FIN_Y);
    assign mul_last = in_mul && (cnt_reg == CW'(WIDTH-1));
    assign exp_bit  = EXP[bit_idx_reg];

    // Operand b is below P < 2^(WIDTH-1); its top bit and the sum's carry
    // out of the final reduction are always zero.
    assign unused_bits = {b_sh_reg[WIDTH-1], sum_red[WIDTH]};

    // Multiplier operand routing for the current schedule step
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_reg)
            S_EXP_SQR: begin op_a = r_reg; op_b = r_reg; end
            S_EXP_MUL: begin op_a = r_reg; op_b = z_reg; end
            S_FIN_X:   begin op_a = x_reg; op_b = r_reg; end
            S_FIN_Y:   begin op_a = y_reg; op_b = r_reg; end
            default:   begin op_a = '0;    op_b = '0;    end
        endcase
    end

    // One double-and-add step; each half needs at most one subtract of P
    always_comb begin
        dbl      = {acc_reg, 1'b0};
        dbl_red  = (dbl >= {1'b0, P}) ? (dbl - {1'b0, P}) : dbl;
        sum      = dbl_red + (b_sh_reg[WIDTH-2] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
        sum_red  = (sum >= {1'b0, P}) ? (sum - {1'b0, P}) : sum;
        acc_next = sum_red[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: fixed schedule, transitions only at multiply ends
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) state_next = S_EXP_SQR;
            end
            S_EXP_SQR: begin
                if (mul_last) begin
                    if (exp_bit)                 state_next = S_EXP_MUL;
                    else if (bit_idx_reg == '0)  state_next = S_FIN_X;
                    else                         state_next = S_EXP_SQR;
                end
            end
            S_EXP_MUL: begin
                if (mul_last) state_next = (bit_idx_reg == '0) ? S_FIN_X : S_EXP_SQR;
            end
            S_FIN_X: begin
                if (mul_last) state_next = S_FIN_Y;
            end
            S_FIN_Y: begin
                if (mul_last) state_next = S_DONE;
            end
            S_DONE: begin
                if (out_valid_reg && out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, multiplier sequencing, result publishing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_reg         <= '0;
            y_reg         <= '0;
            z_reg         <= '0;
            r_reg         <= '0;
            x_res_reg     <= '0;
            y_res_reg     <= '0;
            a_reg         <= '0;
            b_sh_reg      <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            out_valid_reg <= 1'b0;
            x_out_reg     <= '0;
            y_out_reg     <= '0;
        end else begin
            if (accept) begin
                x_reg       <= x_in;
                y_reg       <= y_in;
                z_reg       <= z_in;
                r_reg       <= WIDTH'(1);
                bit_idx_reg <= CW'(WIDTH-2);
                cnt_reg     <= '0;
            end else if (in_mul) begin
                if (cnt_reg == '0) begin
                    a_reg    <= op_a;
                    b_sh_reg <= op_b;
                    acc_reg  <= '0;
                    cnt_reg  <= CW'(1);
                end else begin
                    acc_reg  <= acc_next;
                    b_sh_reg <= {b_sh_reg[WIDTH-2:0], 1'b0};
                    if (mul_last) begin
                        cnt_reg <= '0;
                        case (state_reg)
                            S_EXP_SQR: begin
                                r_reg <= acc_next;
                                if (!exp_bit) bit_idx_reg <= bit_idx_reg - CW'(1);
                            end
                            S_EXP_MUL: begin
                                r_reg       <= acc_next;
                                bit_idx_reg <= bit_idx_reg - CW'(1);
                            end
                            S_FIN_X: x_res_reg <= acc_next;
                            default: y_res_reg <= acc_next;
                        endcase
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end else if (state_reg == S_DONE) begin
                if (!out_valid_reg) begin
                    out_valid_reg <= 1'b1;
                    x_out_reg     <= force_zero ? '0 : x_res_reg;
                    y_out_reg     <= force_zero ? '0 : y_res_reg;
                end else if (out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

`ifdef ZERO_CHECK_EN
    logic zero_reg, err_reg;

    // Record Z==0 at accept and expose it alongside the published result
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            if (accept) zero_reg <= (z_in == '0);
            if (state_reg == S_DONE && !out_valid_reg) err_reg <= zero_reg;
        end
    end

    assign force_zero = zero_reg;
    assign out_err    = err_reg;
`else
    assign force_zero = 1'b0;
    assign out_err    = 1'b0;
`endif

endmodule

// File: doc/projective_to_affine.md
Name: projective_to_affine

Overview:
- Converts a projective Edwards25519 point (X:Y:Z), as produced by the point-addition stage, to affine (x, y) = (X/Z, Y/Z) mod p.
- Sits directly downstream of point addition, at the end of scalar multiplication, before encoding.
- Z^-1 is computed by Fermat exponentiation, Z^(p-2), using one internal bit-serial modular multiplier. The schedule is fixed and constant-time, with no data-dependent skips.
- All values are plain residues mod p, not in Montgomery form.

Parameters:
- WIDTH, 256, operand width in bits.
- P, 2^255-19, field modulus. The exponent P-2 is derived internally.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input point valid.
- in_ready  output  1  block idle and able to accept a point.
- x_in  input  WIDTH  projective X, must be < P.
- y_in  input  WIDTH  projective Y, must be < P.
- z_in  input  WIDTH  projective Z, must be < P.
- out_valid  output  1  affine result valid.
- out_ready  input  1  consumer accepts result.
- x_out  output  WIDTH  affine x.
- y_out  output  WIDTH  affine y.
- out_err  output  1  Z was zero; only meaningful with ZERO_CHECK_EN.

Behaviour:
- Reset values (async, reset_n low):
  - in_ready=1.
  - out_valid=0.
  - x_out=0, y_out=0.
  - out_err=0.
  - State IDLE; all internal registers cleared.
- Reset mid-operation aborts the computation. No output is produced. in_ready=1 on the first clock edge after reset_n rises.
- Accept: handshake fires when in_valid & in_ready at a rising edge.
  - X, Y, Z are latched at that edge.
  - in_ready=0 from the next cycle until the result has been consumed.
  - Input changes after acceptance are ignored.
- Multiplier (MUL sub-sequence), computes a*b mod P:
  - 1 load cycle, then 255 iterations, MSB first, i = 254 down to 0.
  - Each iteration: acc = 2*acc mod P; if b[i], acc = acc + a mod P.
  - Each step reduces with at most one conditional subtract of P.
  - Exactly 256 cycles per multiply.
- Exponentiation:
  - r = 1.
  - For each bit of P-2, from bit 254 down to 0: r = r*r; if the bit is set, r = r*Z.
  - P-2 = 0x7FFF...FFEB contains 253 set bits, giving 255 squarings and 253 multiplies.
  - The initial squarings of 1 are executed, not skipped.
- Finalize: x = X*r, then y = Y*r. Total 510 multiplies.
- States:
  - IDLE → EXP_SQR on accept.
  - EXP_SQR → EXP_MUL if the exponent bit is set, else next bit's EXP_SQR (or FIN_X after bit 0).
  - EXP_MUL → next bit's EXP_SQR, or FIN_X after bit 0.
  - FIN_X → FIN_Y → DONE.
  - DONE → IDLE on out_ready.
- Latency: out_valid rises exactly 510*256+1 = 130561 cycles after the accept edge, independent of data.
- Output hold: in DONE, out_valid=1 and x_out/y_out/out_err are stable until out_valid & out_ready at a rising edge.
  - out_valid=0 and in_ready=1 in the cycle after that edge.
  - A new input cannot be accepted in the same cycle as the output handshake.
- out_ready is ignored outside DONE.
- Z=0: the Fermat result is 0, so x_out=0 and y_out=0. Latency is unchanged.
- Inputs ≥ P: the result is unspecified but the latency is still fixed. The block must not hang.

Optional Feature:
- Macro: ZERO_CHECK_EN.
- When defined:
  - Z==0 is detected at accept and registered.
  - In DONE, out_err=1 and x_out=y_out=0.
  - Full latency is still consumed, to stay constant-time.
- When undefined: out_err is tied 0 and no comparator is built.

Test Plan:
- X=5, Y=7, Z=1 → at cycle +130561: x_out=5, y_out=7, out_err=0.
- X=2, Y=4, Z=2 → x_out=1, y_out=2.
- X=1, Y=5, Z=P-1 → x_out=P-1, y_out=P-5.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - x_out/y_out/out_valid stay stable and in_ready=0 throughout.
  - With out_ready=1: out_valid=0 and in_ready=1 next cycle.
  - in_valid held high during DONE is not accepted.
- Reset: assert reset_n=0 at cycle +5000 of an operation.
  - out_valid=0 immediately; out_valid never rises for that operation.
  - in_ready=1 after release.
  - A new point (X=3, Y=9, Z=3) gives x_out=1, y_out=3.
- Z=0, X=Y=9 → x_out=y_out=0 at cycle +130561; out_err=1 with ZERO_CHECK_EN, 0 without.
